// File: rtl/lathe_panel_cmd.sv
// Operator-panel front end for the lathe PLC core: input conditioning,
// mode arbitration, start shaping and safety interlocks.

// One conditioned panel input: two-flop synchroniser followed by a
// counter debouncer that only accepts a change after it has been stable.
module lathe_panel_deb #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20,
  parameter bit RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  logic [1:0]       sync;
  logic [DEB_W-1:0] cnt;

  // Two-stage synchroniser; the stage-2 output is the debouncer input.
  always_ff @(posedge clk) begin
    if (rst) sync <= {2{RST_VAL}};
    else     sync <= {sync[0], raw};
  end

  // Count consecutive disagreeing cycles; flip once the run is long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= RST_VAL;
    end else if (sync[1] == stable) begin
      cnt <= '0;
    end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
      cnt    <= '0;
      stable <= sync[1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module lathe_panel_cmd #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start_raw,
  input  logic btn_stop_raw,
  input  logic estop_n_raw,
  input  logic sw_auto_raw,
  input  logic sw_man_raw,
  input  logic run_fb,
  output logic start,
  output logic stop,
  output logic AUTO,
  output logic MAN,
  output logic estop_active,
  output logic sel_fault
);

  localparam int NUM_IN = 5;
  // Lane order: 0 start, 1 stop, 2 estop_n, 3 auto, 4 man.
  // E-stop contact idles closed, so its lane resets to 1.
  localparam logic [NUM_IN-1:0] RST_VALS = 5'b00100;

  typedef enum logic [1:0] {OFF, AUTO_M, MAN_M, ESTOP} state_t;

  logic [NUM_IN-1:0] raw_in;
  logic [NUM_IN-1:0] stb;
  logic start_s, stop_s, estop_n_s, auto_s, man_s;
  logic start_d, stop_d;
  logic start_rise, stop_rise;
  state_t state, state_n, req;
  logic start_n, stop_n;

  assign raw_in = {sw_man_raw, sw_auto_raw, estop_n_raw, btn_stop_raw, btn_start_raw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
    lathe_panel_deb #(
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W),
      .RST_VAL    (RST_VALS[i])
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_in[i]),
      .stable (stb[i])
    );
  end

  assign start_s   = stb[0];
  assign stop_s    = stb[1];
  assign estop_n_s = stb[2];
  assign auto_s    = stb[3];
  assign man_s     = stb[4];

  // Delayed copies of the debounced buttons for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_d <= 1'b0;
      stop_d  <= 1'b0;
    end else begin
      start_d <= start_s;
      stop_d  <= stop_s;
    end
  end

  assign start_rise = start_s & ~start_d;
  assign stop_rise  = stop_s & ~stop_d;

  // Mode state register.
  always_ff @(posedge clk) begin
    if (rst) state <= OFF;
    else     state <= state_n;
  end

  // Mode arbitration and command shaping; E-stop wins over everything,
  // mode changes wait for the spindle cycle to finish, stop masks start.
  always_comb begin
    req = OFF;
    if (auto_s && !man_s)      req = AUTO_M;
    else if (man_s && !auto_s) req = MAN_M;

    state_n = state;
    if (!estop_n_s)           state_n = ESTOP;
    else if (state == ESTOP) begin
      if (stop_rise)          state_n = OFF;
    end else if (!run_fb)     state_n = req;

    stop_n  = stop_s | (state == ESTOP);
    start_n = 1'b0;
    case (state)
      AUTO_M:  start_n = start_rise;
      MAN_M:   start_n = start_s;
      default: start_n = 1'b0;
    endcase
    if (stop_n) start_n = 1'b0;
  end

  // Registered command outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      start        <= 1'b0;
      stop         <= 1'b0;
      AUTO         <= 1'b0;
      MAN          <= 1'b0;
      estop_active <= 1'b0;
      sel_fault    <= 1'b0;
    end else begin
      start        <= start_n;
      stop         <= stop_n;
      AUTO         <= (state == AUTO_M);
      MAN          <= (state == MAN_M);
      estop_active <= (state == ESTOP);
      sel_fault    <= auto_s & man_s;
    end
  end

endmodule

// File: tb/tb_lathe_panel_cmd.sv
// Scoreboard bench for lathe_panel_cmd with DEB_CYCLES=4. Stimulus queues the
// expected output vector {start,stop,AUTO,MAN,estop_active,sel_fault} for the
// cycle it must appear; the monitor checks due entries and flags any output
// change that nothing predicted.
module tb_lathe_panel_cmd;

  logic clk = 1'b0;
  logic rst;
  logic btn_start_raw, btn_stop_raw, estop_n_raw, sw_auto_raw, sw_man_raw, run_fb;
  logic start, stop, AUTO, MAN, estop_active, sel_fault;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 0;
  logic [5:0] prev = '0;

  lathe_panel_cmd #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_start_raw (btn_start_raw),
    .btn_stop_raw  (btn_stop_raw),
    .estop_n_raw   (estop_n_raw),
    .sw_auto_raw   (sw_auto_raw),
    .sw_man_raw    (sw_man_raw),
    .run_fb        (run_fb),
    .start         (start),
    .stop          (stop),
    .AUTO          (AUTO),
    .MAN           (MAN),
    .estop_active  (estop_active),
    .sel_fault     (sel_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Queue an expectation, kept sorted by cycle.
  task automatic expect_at(input int c, input logic [5:0] v, input string nm);
    exp_t it;
    int   pos;
    it.cyc = c; it.vec = v; it.name = nm;
    pos = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > c) begin pos = i; break; end
    end
    q.insert(pos, it);
  endtask

  // Inputs change 2 time units after the edge; cyc then equals the edge count.
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Monitor on the falling edge.
  always @(negedge clk) begin
    logic [5:0] v;
    exp_t it;
    if (mon_en) begin
      v = {start, stop, AUTO, MAN, estop_active, sel_fault};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        it = q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL %s: expectation for cycle %0d was never checked (now %0d)", it.name, it.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        it = q.pop_front();
        n_cmp++;
        if (v !== it.vec) begin
          n_bad++;
          $display("FAIL %s @%0d: got %b, want %b", it.name, cyc, v, it.vec);
        end
      end else if (v !== prev) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_change @%0d: got %b, was %b", cyc, v, prev);
      end
      prev = v;
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    btn_start_raw = 0; btn_stop_raw = 0; estop_n_raw = 1;
    sw_auto_raw = 0; sw_man_raw = 0; run_fb = 0;
    tick(3);
    rst = 1'b0;
    expect_at(cyc + 1, 6'b000000, "reset_state");
    mon_en = 1;
    tick(2);

    // Select AUTO: stable +6, state +7, AUTO output +8.
    t = cyc; sw_auto_raw = 1;
    expect_at(t + 8, 6'b001000, "enter_auto");
    tick(12);

    // Three-cycle glitch on start is filtered.
    t = cyc; btn_start_raw = 1; tick(3); btn_start_raw = 0;
    expect_at(t + 10, 6'b001000, "glitch_no_start");
    tick(12);

    // Start held 10 cycles in AUTO: a single pulse at +7.
    t = cyc; btn_start_raw = 1;
    expect_at(t + 7, 6'b101000, "auto_pulse_rise");
    expect_at(t + 8, 6'b001000, "auto_pulse_fall");
    tick(10); btn_start_raw = 0;
    tick(12);

    // Switch to MAN while running: mode held until run_fb falls.
    t = cyc; run_fb = 1; sw_auto_raw = 0; sw_man_raw = 1;
    expect_at(t + 12, 6'b001000, "auto_held_running");
    tick(12);
    t = cyc; run_fb = 0;
    expect_at(t + 2, 6'b000100, "man_after_run_fb");
    tick(6);

    // Jog in MAN with an overlapping stop press.
    t = cyc; btn_start_raw = 1;
    expect_at(t + 7,  6'b100100, "jog_on");
    expect_at(t + 12, 6'b010100, "jog_stop_overrides");
    expect_at(t + 17, 6'b100100, "jog_resume");
    expect_at(t + 27, 6'b000100, "jog_off");
    tick(5); btn_stop_raw = 1;
    tick(5); btn_stop_raw = 0;
    tick(10); btn_start_raw = 0;
    tick(12);

    // Back to AUTO.
    t = cyc; sw_man_raw = 0; sw_auto_raw = 1;
    expect_at(t + 8, 6'b001000, "reenter_auto");
    tick(12);

    // E-stop while running.
    t = cyc; run_fb = 1; estop_n_raw = 0;
    expect_at(t + 8, 6'b010010, "estop_engaged");
    tick(12);
    t = cyc; estop_n_raw = 1; run_fb = 0;
    expect_at(t + 10, 6'b010010, "estop_latched");
    tick(12);
    t = cyc; btn_stop_raw = 1;
    expect_at(t + 8, 6'b010000, "estop_ack_off");
    expect_at(t + 9, 6'b011000, "estop_ack_auto");
    tick(10); btn_stop_raw = 0;
    expect_at(t + 17, 6'b001000, "stop_release");
    tick(12);

    // Both selectors closed.
    t = cyc; sw_man_raw = 1;
    expect_at(t + 7, 6'b001001, "sel_fault_set");
    expect_at(t + 8, 6'b000001, "sel_fault_off");
    tick(12);
    t = cyc; btn_start_raw = 1; tick(10); btn_start_raw = 0;
    expect_at(t + 12, 6'b000001, "sel_fault_no_start");
    tick(12);
    t = cyc; sw_man_raw = 0;
    expect_at(t + 7, 6'b000000, "sel_fault_clear");
    expect_at(t + 8, 6'b001000, "auto_after_fault");
    tick(12);

    // Reset during a start pulse with a stop debounce in progress.
    t = cyc; btn_start_raw = 1;
    expect_at(t + 7, 6'b101000, "pre_reset_pulse");
    expect_at(t + 8, 6'b000000, "reset_clears");
    tick(4); btn_stop_raw = 1;
    tick(3); rst = 1;
    tick(2); rst = 0;
    t = cyc;
    expect_at(t + 7, 6'b010000, "post_reset_debounce");
    expect_at(t + 8, 6'b011000, "post_reset_auto");
    tick(12);
    t = cyc; btn_start_raw = 0; btn_stop_raw = 0;
    expect_at(t + 7, 6'b001000, "final_release");
    tick(12);

    mon_en = 0;
    while (q.size() > 0) begin
      exp_t it;
      it = q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", it.name, it.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lathe_panel_cmd.md
Name: lathe_panel_cmd

Overview:
- Operator-panel front end that produces the command inputs for the lathe PLC core: start, stop, AUTO and MAN.
- Synchronises and debounces the raw panel buttons, switches and the E-stop contact.
- Arbitrates the operating mode and shapes the start command: a single-cycle pulse in AUTO, hold-to-jog in MAN.
- Enforces safety interlocks: stop-over-start priority, E-stop lockout and mode changes only while stopped.

Parameters:
- DEB_CYCLES, 500000: consecutive stable cycles required before a debounced input changes (10 ms at 50 MHz).
- DEB_W, 20: debounce counter width; must satisfy 2^DEB_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_start_raw  input  1  start pushbutton, asynchronous, 1 = pressed.
- btn_stop_raw  input  1  stop pushbutton, asynchronous, 1 = pressed.
- estop_n_raw  input  1  E-stop contact, asynchronous, 0 = E-stop engaged.
- sw_auto_raw  input  1  AUTO selector contact, asynchronous.
- sw_man_raw  input  1  MAN selector contact, asynchronous.
- run_fb  input  1  run-latch feedback from the PLC core, 1 = spindle cycle active; synchronous to clk.
- start  output  1  start command to the PLC core.
- stop  output  1  stop command to the PLC core.
- AUTO  output  1  AUTO mode enable.
- MAN  output  1  MAN mode enable.
- estop_active  output  1  1 while in the ESTOP state.
- sel_fault  output  1  1 while both selector contacts read closed.

Behaviour:
- Synchroniser: two flip-flops on each raw input.
- Synchroniser reset values: buttons 0, estop_n 1, switches 0.
- Debounce, per input:
  - A counter increments on each cycle where the synchronised value differs from the stable value.
  - Any cycle where they match clears the counter.
  - On the cycle the counter reaches DEB_CYCLES-1 while still differing, the stable value flips on the next edge and the counter clears.
  - Total latency from raw change to stable change: DEB_CYCLES + 2 cycles.
  - Stable reset values: start 0, stop 0, estop_n 1, auto 0, man 0.
- Edge detect: a registered copy of the stable start and stop values gives start_rise and stop_rise.
- Mode FSM states: OFF, AUTO_M, MAN_M, ESTOP. Reset enters OFF.
- Requested mode:
  - auto=1 and man=0 gives AUTO_M.
  - man=1 and auto=0 gives MAN_M.
  - both=0 gives OFF.
  - both=1 gives OFF and sets sel_fault=1 for as long as both remain 1.
- OFF, AUTO_M and MAN_M transitions:
  - A transition to the requested mode is taken only when run_fb=0.
  - While run_fb=1 the current mode is held; the change takes effect on the first cycle after run_fb falls, if still requested.
- Any state goes to ESTOP when stable estop_n=0. This has the highest priority and ignores run_fb.
- Leaving ESTOP: go to OFF only on a stop_rise while stable estop_n=1 (acknowledge). Otherwise stay in ESTOP.
- Outputs, all registered and updated one cycle after the FSM or debounced change:
  - AUTO=1 only in AUTO_M; MAN=1 only in MAN_M.
  - estop_active=1 only in ESTOP.
  - stop = stable stop OR (state==ESTOP).
  - start in AUTO_M: one-cycle pulse on start_rise.
  - start in MAN_M: equals the stable start level (jog).
  - start in OFF and ESTOP: 0.
- Interlock: start is forced to 0 on any cycle where stop would be 1, so start and stop are never both 1. A simultaneous start_rise and stop_rise therefore yields stop only.
- A start_rise in AUTO_M while run_fb=1 still pulses start; the PLC latch absorbs it harmlessly.
- Reset mid-operation: within one edge of rst=1, all outputs go to 0, counters clear, synchronisers take their reset values and the state becomes OFF.

Test Plan:
- DEB_CYCLES=4: raw start glitch of 3 cycles -> no stable change, start stays 0. Raw start held 10 cycles with sw_auto=1 -> exactly one start pulse, 1 cycle wide, 7 cycles after the raw rise (2 synchroniser + 4 debounce + 1 output register).
- MAN mode, start held 20 cycles -> start=1 continuously from latency 7 until 7 cycles after release. Stop pressed concurrently -> start=0 and stop=1 for the overlap.
- AUTO_M with run_fb=1, selector switched to MAN -> AUTO stays 1 and MAN stays 0. run_fb falls -> next cycle FSM enters MAN_M, MAN=1 the cycle after.
- estop_n_raw=0 while in AUTO with run_fb=1 -> estop_active=1, stop=1, AUTO=0. Release the E-stop without pressing stop -> remains in ESTOP. Stop pressed -> OFF, estop_active=0, then the selected mode is re-entered.
- Both selectors closed -> sel_fault=1, AUTO=MAN=0, start presses produce start=0.
- rst asserted during an AUTO_M start pulse and a debounce count in progress -> all outputs 0 the next cycle. After release, the state is OFF and a fresh full debounce is needed for any change.
